// File: rtl/asic_config_sequencer.sv
// asic_config_sequencer: latches host config fields and cut lists, then streams
// them to the ASIC as HEADER, F1..F9, L1[], L2[] over a valid/ready link.
module asic_config_sequencer #(
    parameter int                DATA_W = 16,
    parameter int                CUT_N  = 15,
    parameter logic [DATA_W-1:0] HEADER = 16'hA5C3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cfg_value,
    input  logic [31:0]       cfg_trig,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              done_pulse,
    output logic              busy,
    output logic              locked,
    output logic [2:0]        cfg_err
);
    typedef enum logic [2:0] {INIT, IDLE, CONFIG, SEND, DONE, LOCKED} state_t;
    localparam logic [3:0] FULL    = 4'(CUT_N);
    localparam logic [5:0] L2_BASE = 6'(10 + CUT_N);
    localparam logic [5:0] LAST    = 6'(9 + 2 * CUT_N);
    state_t            r_state, w_next;
    logic [31:0]       r_trig, r_value;
    logic [DATA_W-1:0] r_f  [9];
    logic [DATA_W-1:0] r_l1 [CUT_N];
    logic [DATA_W-1:0] r_l2 [CUT_N];
    logic [3:0]        r_ptr1, r_ptr2, w_ptr1, w_ptr2, w_i1, w_i2, w_i3;
    logic [5:0]        r_cnt, w_cnt;
    logic [2:0]        r_err, w_err;
    logic              r_tx_valid, r_done, r_busy, r_locked;
    logic [DATA_W-1:0] r_tx_data, w_word;
    logic              w_cfg, w_hs, w_push1, w_push2, w_unused;
    assign w_unused = ^r_trig[30:12];
    assign w_cfg    = r_state == CONFIG && !r_trig[0];
    assign w_hs     = r_tx_valid && tx_ready;
    assign w_push1  = w_cfg && r_trig[10] && r_ptr1 != FULL;
    assign w_push2  = w_cfg && r_trig[11] && r_ptr2 != FULL;
    always_comb begin
        w_next = (r_state == INIT) ? IDLE : (r_state == DONE) ? CONFIG : r_state;
        w_ptr1 = r_ptr1;
        w_ptr2 = r_ptr2;
        w_err  = r_err;
        w_cnt  = r_cnt;
        if (r_state == SEND) begin
            if (w_hs) begin
                w_cnt  = r_cnt + 6'd1;
                w_next = (r_cnt == LAST) ? DONE : SEND;
            end
        end else if (r_state != INIT && r_trig[0]) begin
            if (r_value == 32'd1) begin
                w_next = CONFIG;
                w_ptr1 = '0;
                w_ptr2 = '0;
                w_err  = '0;
            end else if (r_value == 32'd2) begin
                w_next = LOCKED;
            end
        end else if (r_state == CONFIG) begin
            if (r_trig[10]) begin
                if (w_push1) w_ptr1 = r_ptr1 + 4'd1;
                else w_err[0] = 1'b1;
            end
            if (r_trig[11]) begin
                if (w_push2) w_ptr2 = r_ptr2 + 4'd1;
                else w_err[0] = 1'b1;
            end
            if (r_trig[31]) begin
                if (|r_trig[11:1]) w_err[2] = 1'b1;
                else if (r_ptr1 != FULL || r_ptr2 != FULL) w_err[1] = 1'b1;
                else begin
                    w_next = SEND;
                    w_cnt  = '0;
                end
            end
        end
    end
    // The word for the next counter value is preloaded so tx_data is registered.
    assign w_i1   = 4'(w_cnt - 6'd1);
    assign w_i2   = 4'(w_cnt - 6'd10);
    assign w_i3   = 4'(w_cnt - L2_BASE);
    assign w_word = (w_cnt == 6'd0) ? HEADER :
                    (w_cnt < 6'd10) ? r_f[w_i1] :
                    (w_cnt < L2_BASE) ? r_l1[w_i2] : r_l2[w_i3];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= INIT;
            r_trig     <= '0;
            r_value    <= '0;
            r_ptr1     <= '0;
            r_ptr2     <= '0;
            r_cnt      <= '0;
            r_err      <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_locked   <= 1'b0;
            r_done     <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_next;
            r_trig     <= cfg_trig;
            r_value    <= cfg_value;
            r_ptr1     <= w_ptr1;
            r_ptr2     <= w_ptr2;
            r_cnt      <= w_cnt;
            r_err      <= w_err;
            r_tx_valid <= w_next == SEND;
            r_busy     <= w_next == SEND;
            r_locked   <= w_next == LOCKED;
            r_done     <= r_state == INIT || w_next == DONE;
            r_tx_data  <= (w_next == SEND) ? w_word : '0;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 9; i++) r_f[i] <= '0;
            for (int i = 0; i < CUT_N; i++) r_l1[i] <= '0;
            for (int i = 0; i < CUT_N; i++) r_l2[i] <= '0;
        end else begin
            for (int i = 1; i < 10; i++) if (w_cfg && r_trig[i]) r_f[i-1] <= r_value[DATA_W-1:0];
            if (w_push1) r_l1[r_ptr1] <= r_value[DATA_W-1:0];
            if (w_push2) r_l2[r_ptr2] <= r_value[DATA_W-1:0];
        end
    end
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign done_pulse = r_done;
    assign busy       = r_busy;
    assign locked     = r_locked;
    assign cfg_err    = r_err;
endmodule

// File: tb/tb_asic_config_sequencer.sv
// tb_asic_config_sequencer: table vectors, hand sequences and random commands
// checked against a queue-based model of the configuration and transfer.
module tb_asic_config_sequencer;
    localparam logic [15:0] HDR = 16'hA5C3;
    localparam logic [31:0] START = 32'h8000_0000;
    typedef struct packed {
        logic [31:0] t;
        logic [31:0] v;
        logic [2:0]  err;
        logic        lock;
    } vec_t;
    logic        clk = 1'b0, reset_n = 1'b0, tx_ready = 1'b0;
    logic [31:0] cfg_value = '0, cfg_trig = '0;
    logic        tx_valid, done_pulse, busy, locked;
    logic [15:0] tx_data;
    logic [2:0]  cfg_err;
    int          n_vec = 0, n_bad = 0;
    logic [15:0] mf [9];
    logic [15:0] ml1[$], ml2[$], rx[$], ex[$];
    logic [2:0]  merr;
    bit          m_cfg, m_lock;
    vec_t        tbl [12];
    int          fv [9];
    int          lv [15];
    always #5 clk = ~clk;
    asic_config_sequencer dut (
        .clk(clk), .reset_n(reset_n), .cfg_value(cfg_value), .cfg_trig(cfg_trig),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .done_pulse(done_pulse), .busy(busy), .locked(locked), .cfg_err(cfg_err)
    );
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic m_reset();
        foreach (mf[i]) mf[i] = '0;
        ml1.delete();
        ml2.delete();
        merr = '0;
        m_cfg = 0;
        m_lock = 0;
    endtask
    task automatic m_apply(input logic [31:0] t, input logic [31:0] v, output bit go);
        go = 0;
        if (t[0]) begin
            if (v == 1) begin
                m_cfg = 1; m_lock = 0; merr = '0;
                ml1.delete(); ml2.delete();
            end else if (v == 2) begin
                m_cfg = 0; m_lock = 1;
            end
            return;
        end
        if (!m_cfg) return;
        for (int i = 1; i < 10; i++) if (t[i]) mf[i-1] = v[15:0];
        if (t[10]) begin
            if (ml1.size() < 15) ml1.push_back(v[15:0]);
            else merr[0] = 1'b1;
        end
        if (t[11]) begin
            if (ml2.size() < 15) ml2.push_back(v[15:0]);
            else merr[0] = 1'b1;
        end
        if (t[31]) begin
            if (|t[11:1]) merr[2] = 1'b1;
            else if (ml1.size() != 15 || ml2.size() != 15) merr[1] = 1'b1;
            else go = 1;
        end
    endtask
    task automatic reset_seq();
        logic [3:0] seen;
        reset_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out", {tx_valid, tx_data, done_pulse, busy, locked, cfg_err}, '0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen[k] = done_pulse;
        end
        tick();
        chk("init_pulse", seen, 4'b0010);
    endtask
    task automatic receive(input bit bp, input bit poke);
        int cyc = 0, vcyc = 0;
        bit stall = 0, fin = 0;
        logic [15:0] hold = '0;
        rx.delete();
        while (!fin && cyc < 1000) begin
            tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && cyc == 10) begin cfg_trig = 32'd1; cfg_value = 32'd1; end
            if (poke && cyc == 11) cfg_trig = '0;
            @(negedge clk);
            if (stall) chk("hold", {tx_valid, tx_data}, {1'b1, hold});
            if (tx_valid) vcyc++;
            if (tx_valid && tx_ready) rx.push_back(tx_data);
            stall = tx_valid && !tx_ready;
            hold = tx_data;
            if (done_pulse) begin
                fin = 1;
                chk("done_end", {tx_valid, busy}, 2'b00);
            end
            tick();
            cyc++;
        end
        if (!fin) chk("done_timeout", 0, 1);
        if (!bp) chk("valid_cycles", vcyc, 40);
        tx_ready = 1'b0;
    endtask
    task automatic expect_tx(input string nm);
        ex.delete();
        ex.push_back(HDR);
        foreach (mf[i]) ex.push_back(mf[i]);
        foreach (ml1[i]) ex.push_back(ml1[i]);
        foreach (ml2[i]) ex.push_back(ml2[i]);
        chk({nm, "_len"}, rx.size(), ex.size());
        foreach (ex[i]) if (i < rx.size()) chk($sformatf("%s_w%0d", nm, i), rx[i], ex[i]);
    endtask
    task automatic cmd(input logic [31:0] t, input logic [31:0] v, input bit bp = 0, input bit poke = 0);
        bit go;
        m_apply(t, v, go);
        cfg_trig = t;
        cfg_value = v;
        tick();
        cfg_trig = '0;
        cfg_value = $urandom;
        tick();
        chk("err", cfg_err, merr);
        chk("locked", locked, m_lock);
        if (go) begin
            chk("start", {busy, tx_valid, tx_data}, {2'b11, HDR});
            receive(bp, poke);
            expect_tx("tx");
            chk("err_after", {cfg_err, locked}, {merr, m_lock});
        end else begin
            chk("no_tx", {busy, tx_valid}, 2'b00);
        end
    endtask
    initial begin
        logic [31:0] t, v;
        int k, guard;
        tbl[0]  = '{START,         32'd0,  3'b000, 1'b0};
        tbl[1]  = '{32'h0000_0400, 32'd5,  3'b000, 1'b0};
        tbl[2]  = '{32'h0000_0001, 32'd7,  3'b000, 1'b0};
        tbl[3]  = '{32'h0000_0001, 32'd1,  3'b000, 1'b0};
        tbl[4]  = '{START,         32'd0,  3'b010, 1'b0};
        tbl[5]  = '{32'h0000_0021, 32'd2,  3'b010, 1'b1};
        tbl[6]  = '{32'h8000_0C00, 32'd3,  3'b010, 1'b1};
        tbl[7]  = '{32'h0000_0001, 32'd1,  3'b000, 1'b0};
        tbl[8]  = '{32'h8000_0020, 32'd77, 3'b100, 1'b0};
        tbl[9]  = '{32'h8000_0001, 32'd3,  3'b100, 1'b0};
        tbl[10] = '{32'h0000_0001, 32'd2,  3'b100, 1'b1};
        tbl[11] = '{32'h0000_0001, 32'd1,  3'b000, 1'b0};
        fv = '{0, 200, 500, 1, 5, 578, 0, 0, 0};
        for (int j = 0; j < 15; j++) lv[j] = j == 0 ? 256 : j == 1 ? 17 : j == 2 ? 171 : j == 14 ? 496 : 342;
        m_reset();
        reset_seq();
        for (int i = 0; i < 12; i++) begin
            cmd(tbl[i].t, tbl[i].v);
            chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].err);
            chk($sformatf("tbl%0d_lock", i), locked, tbl[i].lock);
        end
        cmd(32'd1, 32'd1);
        for (int i = 1; i < 10; i++) cmd(32'd1 << i, 32'(fv[i-1]));
        for (int j = 0; j < 15; j++) cmd(32'h0C00, 32'(lv[j]));
        cmd(START, 32'd0);
        if (rx.size() == 40) begin
            chk("spec_w6", rx[6], 578);
            chk("spec_w39", rx[39], 496);
        end
        cmd(START, 32'd0, 1, 1);
        cmd(32'd1, 32'd1);
        for (int j = 0; j < 16; j++) cmd(32'h0400, 32'(j));
        chk("overflow", cfg_err, 3'b001);
        cmd(32'd1, 32'd1);
        for (int j = 0; j < 15; j++) cmd(32'h0400, $urandom);
        for (int j = 0; j < 14; j++) cmd(32'h0800, $urandom);
        cmd(START, 32'd0);
        chk("incomplete", cfg_err, 3'b010);
        cmd(32'h8000_0020, 32'd1234);
        chk("collide", cfg_err, 3'b110);
        cmd(32'h0800, 32'd9);
        cmd(START, 32'd0, 1);
        if (rx.size() > 5) chk("f5_written", rx[5], 1234);
        for (int r = 0; r < 6; r++) begin
            cmd(32'd1, 32'd1);
            repeat (40) begin
                t = '0;
                for (int b = 1; b < 12; b++) t[b] = ($urandom_range(0, 3) == 0);
                t[31] = ($urandom_range(0, 7) == 0);
                v = $urandom;
                if ($urandom_range(0, 19) == 0) begin
                    t[0] = 1'b1;
                    v = ($urandom_range(0, 2) == 0) ? 32'd7 : 32'($urandom_range(1, 2));
                end
                cmd(t, v, 1'($urandom_range(0, 1)));
            end
            if (!m_cfg) cmd(32'd1, 32'd1);
            while (ml1.size() < 15 || ml2.size() < 15) cmd(32'h0C00, $urandom);
            cmd(START, 32'd0, 1);
        end
        cfg_trig = START;
        tick();
        cfg_trig = '0;
        tick();
        tx_ready = 1'b1;
        k = 0;
        guard = 0;
        while (k < 20 && guard < 200) begin
            @(negedge clk);
            if (tx_valid && tx_ready) k++;
            tick();
            guard++;
        end
        chk("pre_rst_word20", {tx_valid, tx_data}, {1'b1, ml1[10]});
        reset_n = 1'b0;
        #1;
        chk("rst_async", {tx_valid, busy, done_pulse, cfg_err, tx_data}, '0);
        tx_ready = 1'b0;
        reset_seq();
        m_reset();
        cmd(32'd1, 32'd1);
        for (int j = 0; j < 15; j++) cmd(32'h0C00, $urandom);
        cmd(START, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
